// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// Module      : fetch_queue_pkg
// Description : Shared constants and buffer entry type for the fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [31:0] c_PC_INC   = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry {pc,instr} buffer with push, pop and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  fq_entry_t                push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fq_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    fq_entry_t     mem_q [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign w_do_push = push_i && !full_o && !flush_i;
    assign w_do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch PC, in-flight tracking and decode buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = c_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int          CW           = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC_ALN = {RESET_PC[31:2], 2'b00};

    logic [31:0] fpc_q,     fpc_d;
    logic [31:0] infl_pc_q, infl_pc_d;
    logic        infl_q,    infl_d;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_occ;
    logic          w_full;
    logic          w_empty;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    fq_entry_t     w_head;
    fq_entry_t     w_push_data;
    logic          w_unused;

    assign w_unused = &{1'b0, redirect_pc[1:0]};

    // Counting the in-flight request reserves its slot before the data returns.
    assign w_occ   = w_count + CW'(infl_q);
    assign w_issue = rst_n && !redirect && (w_occ < CW'(DEPTH));
    assign w_push  = infl_q && !redirect && !w_full;
    assign w_pop   = id_valid && !stall && !redirect;

    assign w_push_data.pc    = infl_pc_q;
    assign w_push_data.instr = imem_rdata;

    always_comb begin
        fpc_d     = fpc_q;
        infl_pc_d = infl_pc_q;
        infl_d    = w_issue;
        if (redirect) begin
            fpc_d = {redirect_pc[31:2], 2'b00};
        end else if (w_issue) begin
            fpc_d     = fpc_q + c_PC_INC;
            infl_pc_d = fpc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q     <= RESET_PC_ALN;
            infl_pc_q <= '0;
            infl_q    <= 1'b0;
        end else begin
            fpc_q     <= fpc_d;
            infl_pc_q <= infl_pc_d;
            infl_q    <= infl_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .flush_i     (redirect),
        .head_o      (w_head),
        .count_o     (w_count),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    assign imem_addr = fpc_q;
    assign imem_req  = w_issue;
    assign id_valid  = !w_empty;
    assign id_instr  = id_valid ? w_head.instr : c_NOP;
    assign id_pc     = id_valid ? w_head.pc    : 32'h0000_0000;

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction-buffer entries; SHALL be a power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_addr  output  32  word-aligned fetch address to the instruction port of the BRAM.
REQ-006 imem_req  output  1  high when imem_addr is a real fetch whose data SHALL be captured.
REQ-007 imem_rdata  input  32  instruction word, valid the cycle after imem_addr is presented (synchronous read).
REQ-008 redirect  input  1  one-cycle pulse from EX: branch taken or jump.
REQ-009 redirect_pc  input  32  target address, sampled when redirect is high.
REQ-010 stall  input  1  decode cannot accept this cycle.
REQ-011 id_valid  output  1  id_instr/id_pc hold a valid instruction.
REQ-012 id_instr  output  32  head instruction; 32'h0000_0013 (NOP) when id_valid is low.
REQ-013 id_pc  output  32  address of id_instr.

Function
REQ-014 Fetch PC register fpc SHALL drive imem_addr directly; bits [1:0] SHALL always be 0.
REQ-015 Issue condition: imem_req = !redirect && (count + inflight) < DEPTH, where count is occupancy and inflight is 1 if a request was issued last cycle and not killed.
REQ-016 On an issue, fpc SHALL advance by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0), and the issued PC SHALL be held in a one-entry in-flight register.
REQ-017 In the cycle after an issue, imem_rdata and the in-flight PC SHALL be written into the buffer tail unless killed.
REQ-018 Pop: the head SHALL be removed at the clock edge when id_valid && !stall.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-020 Latency: address issued cycle N, data captured edge end of N+1, id_valid high in N+2 (no bypass).
REQ-021 Throughput: with stall low, one instruction per cycle in steady state.
REQ-022 Redirect (cycle R): buffer SHALL be flushed (count=0), in-flight request SHALL be killed, no issue in R, fpc <= {redirect_pc[31:2],2'b00}; first target fetch issued R+1, id_valid high R+3.
REQ-023 Redirect SHALL take priority over stall, push and pop in the same cycle; id_valid in R is as-before, but no pop takes effect.
REQ-024 Buffer SHALL never overflow: count+inflight bound guarantees a free slot for every capture.
REQ-025 With stall held high, after filling, imem_req SHALL stay low and outputs SHALL remain stable.

Reset
REQ-026 On rst_n low: fpc=RESET_PC, count=0, pointers=0, inflight=0, id_valid=0, id_instr=NOP, id_pc=0, imem_req=0 during reset.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and in-flight data immediately; first fetch at RESET_PC in the first cycle after release.

Structure
REQ-028 Shared package/header SHALL hold RESET_PC default, NOP encoding 32'h0000_0013, and PC increment constant 4.
REQ-029 Storage SHALL be one sub-module fetch_fifo (DEPTH x 64-bit {pc,instr}, push/pop/flush, count, full/empty); fetch_queue holds fpc, in-flight register and issue logic.
REQ-030 Counters SHALL be $clog2(DEPTH)+1 bits; no latches; no combinational path from imem_rdata to id_* outputs.

Verification
REQ-031 Reset release, stall=0, memory word at addr k = k -> id_pc 0,4,8,... from cycle 2, one per cycle, id_instr matches memory.
REQ-032 stall=1 from cycle 5 for 10 cycles -> buffer fills to 4, imem_req low, id_pc frozen; release -> sequence resumes with no skipped or duplicated PC.
REQ-033 redirect with redirect_pc=32'h100 while 3 entries buffered -> id_valid low R+1..R+2, id_pc=32'h100 at R+3, no stale instruction delivered.
REQ-034 redirect and stall high in same cycle, then redirect_pc=32'h203 -> target fetched at 32'h200, stall ignored for flush.
REQ-035 fpc=32'hFFFF_FFF8, no stall -> id_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 rst_n asserted with buffer full and request in flight -> id_valid 0 immediately; after release first id_pc=RESET_PC.
